// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared constants, FSM encoding and magnitude helper for gauss_stat_monitor
package gauss_pkg;

  localparam int SAMPLE_W = 32;  // width of a sample on the stream
  localparam int SIG_W    = 20;  // significant (sign + integer + fraction) bits
  localparam int FRAC     = 12;  // fraction bits; 1.0 sigma = 1 << FRAC
  localparam int VAR_W    = 48;  // variance output width, Q23.24

  localparam logic [SIG_W:0] SIGMA1 = (SIG_W+1)'(1) << FRAC;
  localparam logic [SIG_W:0] SIGMA2 = (SIG_W+1)'(2) << FRAC;
  localparam logic [SIG_W:0] SIGMA3 = (SIG_W+1)'(3) << FRAC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FIN0,
    ST_FIN1,
    ST_DONE
  } state_e;

  // |s| on 21 bits so that the most negative sample (-2^19) has a representable magnitude.
  function automatic logic [SIG_W:0] mag21(input logic signed [SIG_W-1:0] s);
    logic signed [SIG_W:0] w;
    w = {s[SIG_W-1], s};
    mag21 = w[SIG_W] ? ((~w) + 21'd1) : w;
  endfunction

endpackage

// File: rtl/gauss_stat_monitor_if.sv
// rtl/gauss_stat_monitor_if.sv - sample stream, control and result bundle for gauss_stat_monitor
//  start/res_ack         control from the consumer
//  in_valid/in_data      sample stream into the monitor, in_ready back
//  res_valid/busy        status from the monitor
//  *_out                 window results
//  master: stream source / result consumer side; slave: the monitor
interface gauss_stat_monitor_if #(parameter int LOG2_N = 10);
  import gauss_pkg::*;

  logic                start;
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_ready;
  logic                res_valid;
  logic                res_ack;
  logic                busy;
  logic [SAMPLE_W-1:0] mean_out;
  logic [VAR_W-1:0]    var_out;
  logic [SAMPLE_W-1:0] min_out;
  logic [SAMPLE_W-1:0] max_out;
  logic [LOG2_N:0]     cnt1_out;
  logic [LOG2_N:0]     cnt2_out;
  logic [LOG2_N:0]     cnt3_out;
  logic [LOG2_N:0]     err_out;

  modport master (
    output start, in_valid, in_data, res_ack,
    input  in_ready, res_valid, busy, mean_out, var_out, min_out, max_out,
           cnt1_out, cnt2_out, cnt3_out, err_out
  );

  modport slave (
    input  start, in_valid, in_data, res_ack,
    output in_ready, res_valid, busy, mean_out, var_out, min_out, max_out,
           cnt1_out, cnt2_out, cnt3_out, err_out
  );

endinterface

// File: rtl/gauss_accum.sv
// rtl/gauss_accum.sv - per-window sum/sumsq/min/max/sigma-count datapath
//  clk, aclr   clock, asynchronous active-high reset
//  clr_i       restart the window (wins over en_i)
//  en_i        accept data_i this cycle
//  data_i      32-bit sample; low 20 bits are the value, upper bits only checked
//  sum_o, sumsq_o, min_o, max_o, cnt1_o..cnt3_o, err_o   running window statistics
//  last_o      the accepted sample is the last of the window
module gauss_accum
  import gauss_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input  logic                           clk,
  input  logic                           aclr,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic [SAMPLE_W-1:0]            data_i,
  output logic signed [SIG_W+LOG2_N-1:0] sum_o,
  output logic [2*SIG_W+LOG2_N-1:0]      sumsq_o,
  output logic signed [SIG_W-1:0]        min_o,
  output logic signed [SIG_W-1:0]        max_o,
  output logic [LOG2_N:0]                cnt1_o,
  output logic [LOG2_N:0]                cnt2_o,
  output logic [LOG2_N:0]                cnt3_o,
  output logic [LOG2_N:0]                err_o,
  output logic                           last_o
);

  localparam int SUM_W = SIG_W + LOG2_N;
  localparam int SQ_W  = 2*SIG_W + LOG2_N;

  logic signed [SIG_W-1:0]   s;
  logic signed [2*SIG_W-1:0] s_ext;
  logic signed [2*SIG_W-1:0] sq;
  logic [SIG_W:0]            mag;
  logic                      bad_ext;

  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]         sumsq_q, sumsq_d;
  logic signed [SIG_W-1:0] min_q, min_d, max_q, max_d;
  logic [LOG2_N:0]         cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d, err_q, err_d;
  logic [LOG2_N-1:0]       idx_q, idx_d;

  assign s       = data_i[SIG_W-1:0];
  assign s_ext   = (2*SIG_W)'(s);
  assign sq      = s_ext * s_ext;
  assign mag     = mag21(s);
  assign bad_ext = data_i[SAMPLE_W-1:SIG_W] != {(SAMPLE_W-SIG_W){data_i[SIG_W-1]}};
  assign last_o  = en_i && (idx_q == '1);

  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    cnt3_d  = cnt3_q;
    err_d   = err_q;
    idx_d   = idx_q;
    if (clr_i) begin
      sum_d   = '0;
      sumsq_d = '0;
      min_d   = {1'b0, {(SIG_W-1){1'b1}}};
      max_d   = {1'b1, {(SIG_W-1){1'b0}}};
      cnt1_d  = '0;
      cnt2_d  = '0;
      cnt3_d  = '0;
      err_d   = '0;
      idx_d   = '0;
    end else if (en_i) begin
      sum_d   = sum_q + SUM_W'(s);
      // s*s is never negative, so zero-extension is exact
      sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, sq};
      if (s < min_q) min_d = s;
      if (s > max_q) max_d = s;
      if (mag < SIGMA1) cnt1_d = cnt1_q + 1'b1;
      if (mag < SIGMA2) cnt2_d = cnt2_q + 1'b1;
      if (mag < SIGMA3) cnt3_d = cnt3_q + 1'b1;
      if (bad_ext) err_d = err_q + 1'b1;
      idx_d = idx_q + 1'b1;  // wraps to 0 on the last sample
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
      err_q   <= '0;
      idx_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cnt3_q  <= cnt3_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign sum_o   = sum_q;
  assign sumsq_o = sumsq_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign cnt1_o  = cnt1_q;
  assign cnt2_o  = cnt2_q;
  assign cnt3_o  = cnt3_q;
  assign err_o   = err_q;

endmodule

// File: rtl/gauss_stat_monitor.sv
// rtl/gauss_stat_monitor.sv - one-window statistics monitor on the Gaussian sample stream
//  clk   system clock
//  aclr  asynchronous active-high reset
//  bus   gauss_stat_monitor_if.slave: start/res_ack control, in_* sample stream,
//        res_valid/busy status and the registered window results
module gauss_stat_monitor
  import gauss_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input logic                 clk,
  input logic                 aclr,
  gauss_stat_monitor_if.slave bus
);

  state_e state_q, state_d;
  logic   clr;
  logic   xfer;
  logic   last;

  logic signed [SIG_W+LOG2_N-1:0] sum;
  logic [2*SIG_W+LOG2_N-1:0]      sumsq;
  logic signed [SIG_W-1:0]        min_v, max_v;
  logic [LOG2_N:0]                cnt1, cnt2, cnt3, err;

  logic signed [SIG_W-1:0] mean_q;
  logic [2*SIG_W-1:0]      msq_q;
  logic signed [VAR_W-1:0] mean_w;
  logic signed [VAR_W-1:0] mean_sq;
  logic [VAR_W-1:0]        var_d;

  logic [SAMPLE_W-1:0] mean_out_q, min_out_q, max_out_q;
  logic [VAR_W-1:0]    var_out_q;
  logic [LOG2_N:0]     cnt1_out_q, cnt2_out_q, cnt3_out_q, err_out_q;

  assign xfer = bus.in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_ACCUM;
      ST_ACCUM: if (last) state_d = ST_FIN0;
      ST_FIN0:  state_d = ST_FIN1;
      ST_FIN1:  state_d = ST_DONE;
      // start beats res_ack when both arrive together
      ST_DONE:  if (bus.start) state_d = ST_ACCUM;
                else if (bus.res_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Entering ACCUM from IDLE or DONE restarts the window.
  assign clr = (state_d == ST_ACCUM) && (state_q != ST_ACCUM);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  gauss_accum #(.LOG2_N(LOG2_N)) u_accum (
    .clk     (clk),
    .aclr    (aclr),
    .clr_i   (clr),
    .en_i    (xfer),
    .data_i  (bus.in_data),
    .sum_o   (sum),
    .sumsq_o (sumsq),
    .min_o   (min_v),
    .max_o   (max_v),
    .cnt1_o  (cnt1),
    .cnt2_o  (cnt2),
    .cnt3_o  (cnt3),
    .err_o   (err),
    .last_o  (last)
  );

  // The mean of 20-bit samples always fits in 20 bits, so the narrowing casts are exact.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mean_q <= '0;
      msq_q  <= '0;
    end else if (state_q == ST_FIN0) begin
      mean_q <= SIG_W'(sum >>> LOG2_N);
      msq_q  <= (2*SIG_W)'(sumsq >> LOG2_N);
    end
  end

  assign mean_w  = VAR_W'(mean_q);
  assign mean_sq = mean_w * mean_w;
  assign var_d   = {{(VAR_W-2*SIG_W){1'b0}}, msq_q} - mean_sq;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mean_out_q <= '0;
      var_out_q  <= '0;
      min_out_q  <= '0;
      max_out_q  <= '0;
      cnt1_out_q <= '0;
      cnt2_out_q <= '0;
      cnt3_out_q <= '0;
      err_out_q  <= '0;
    end else if (state_q == ST_FIN1) begin
      mean_out_q <= SAMPLE_W'(mean_q);
      var_out_q  <= var_d;
      min_out_q  <= SAMPLE_W'(min_v);
      max_out_q  <= SAMPLE_W'(max_v);
      cnt1_out_q <= cnt1;
      cnt2_out_q <= cnt2;
      cnt3_out_q <= cnt3;
      err_out_q  <= err;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_ACCUM) || (state_q == ST_FIN0) || (state_q == ST_FIN1);
  assign bus.mean_out  = mean_out_q;
  assign bus.var_out   = var_out_q;
  assign bus.min_out   = min_out_q;
  assign bus.max_out   = max_out_q;
  assign bus.cnt1_out  = cnt1_out_q;
  assign bus.cnt2_out  = cnt2_out_q;
  assign bus.cnt3_out  = cnt3_out_q;
  assign bus.err_out   = err_out_q;

endmodule

// File: tb/tb_gauss_stat_monitor.sv
// tb/tb_gauss_stat_monitor.sv - self-checking bench for gauss_stat_monitor with a 16-sample window
`timescale 1ns/1ps
module tb_gauss_stat_monitor;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  gauss_stat_monitor_if #(.LOG2_N(N)) bus ();

  gauss_stat_monitor #(.LOG2_N(N)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  typedef logic [W-1:0][31:0] win_t;

  typedef struct packed {
    logic [31:0] mean;
    logic [47:0] vr;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [4:0]  c3;
    logic [4:0]  er;
  } res_t;

  typedef struct packed {
    win_t smp;
    res_t e;
  } vec_t;

  vec_t vecs [4];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag, input res_t e);
    check({tag, ".mean"}, 64'(bus.mean_out), 64'(e.mean));
    check({tag, ".var"},  64'(bus.var_out),  64'(e.vr));
    check({tag, ".min"},  64'(bus.min_out),  64'(e.mn));
    check({tag, ".max"},  64'(bus.max_out),  64'(e.mx));
    check({tag, ".cnt1"}, 64'(bus.cnt1_out), 64'(e.c1));
    check({tag, ".cnt2"}, 64'(bus.cnt2_out), 64'(e.c2));
    check({tag, ".cnt3"}, 64'(bus.cnt3_out), 64'(e.c3));
    check({tag, ".err"},  64'(bus.err_out),  64'(e.er));
  endtask

  // Reference statistics straight from the definitions: floor mean, E[x^2] - mean^2.
  function automatic res_t model(input win_t w);
    res_t   r;
    longint sum, sumsq, mean, msq, vr;
    int     full, s, mag, hi, mn, mx, c1, c2, c3, er;
    sum = 0; sumsq = 0; mn = 1 << 30; mx = -(1 << 30);
    c1 = 0; c2 = 0; c3 = 0; er = 0;
    for (int i = 0; i < W; i++) begin
      full = $signed(w[i]);
      s = full & 32'h000F_FFFF;
      if (s >= 524288) s = s - 1048576;
      hi = full >>> 19;
      if (hi != 0 && hi != -1) er++;
      mag = (s < 0) ? -s : s;
      if (mag < 4096)  c1++;
      if (mag < 8192)  c2++;
      if (mag < 12288) c3++;
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      sum += s;
      sumsq += longint'(s) * longint'(s);
    end
    mean = (sum >= 0) ? sum / W : -((-sum + W - 1) / W);
    msq  = sumsq / W;
    vr   = msq - mean * mean;
    r.mean = 32'(mean);
    r.vr   = 48'(vr);
    r.mn   = 32'(mn);
    r.mx   = 32'(mx);
    r.c1   = 5'(c1);
    r.c2   = 5'(c2);
    r.c3   = 5'(c3);
    r.er   = 5'(er);
    return r;
  endfunction

  function automatic logic [31:0] rand_sample();
    int k;
    int v;
    k = $urandom_range(0, 9);
    case (k)
      0:       return 32'h0007_FFFF;
      1:       return 32'hFFF8_0000;
      2:       return $urandom;
      default: begin
        v = int'($urandom_range(0, 40000)) - 20000;
        return 32'(v);
      end
    endcase
  endfunction

  // Starts a window, feeds w with in_valid high pct% of cycles, optionally pulses start
  // alongside sample start_at, then keeps offering junk and measures the result latency.
  task automatic run_window(input string tag, input win_t w, input int pct, input int start_at);
    int   idx, guard, lat, extra;
    logic x, got;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; guard = 0;
    while (idx < W && guard < 2000) begin
      bus.in_valid = ($urandom_range(0, 99) < pct);
      bus.in_data  = bus.in_valid ? w[idx] : $urandom;
      bus.start    = bus.in_valid && (idx == start_at);
      @(negedge clk);
      x = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (x) idx++;
      guard++;
    end
    bus.start = 1'b0;
    check({tag, ".accepted"}, 64'(idx), 64'(W));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0001_2345;
    lat = 0; extra = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, ".in_ready_drop"}, 64'(bus.in_ready), 64'd0);
      if (bus.in_valid && bus.in_ready) extra++;
      if (bus.res_valid) got = 1'b1;
    end
    bus.in_valid = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'd3);
    check({tag, ".extra"}, 64'(extra), 64'd0);
  endtask

  initial begin
    win_t w;
    res_t e;

    for (int i = 0; i < W; i++) begin
      vecs[0].smp[i] = 32'h0000_1000;
      vecs[1].smp[i] = (i % 2 == 1) ? 32'hFFFF_F000 : 32'h0000_1000;
      vecs[2].smp[i] = (i == 3) ? 32'h7FF8_0000 : 32'h0;
      vecs[3].smp[i] = (i == 9) ? 32'hFFFF_FFFF : 32'h0;
    end
    vecs[0].e = '{mean: 32'h1000, vr: 48'h0, mn: 32'h1000, mx: 32'h1000,
                  c1: 5'd0, c2: 5'd16, c3: 5'd16, er: 5'd0};
    vecs[1].e = '{mean: 32'h0, vr: 48'h100_0000, mn: 32'hFFFF_F000, mx: 32'h1000,
                  c1: 5'd0, c2: 5'd16, c3: 5'd16, er: 5'd0};
    vecs[2].e = '{mean: 32'hFFFF_8000, vr: 48'h3_C000_0000, mn: 32'hFFF8_0000, mx: 32'h0,
                  c1: 5'd15, c2: 5'd15, c3: 5'd15, er: 5'd1};
    vecs[3].e = '{mean: 32'hFFFF_FFFF, vr: 48'hFFFF_FFFF_FFFF, mn: 32'hFFFF_FFFF, mx: 32'h0,
                  c1: 5'd16, c2: 5'd16, c3: 5'd16, er: 5'd0};

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ack = 1'b0;
    aclr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready",  64'(bus.in_ready),  64'd0);
    check("rst.res_valid", 64'(bus.res_valid), 64'd0);
    check("rst.busy",      64'(bus.busy),      64'd0);
    check_results("rst", '0);
    @(posedge clk); #1;
    aclr = 1'b0;

    for (int k = 0; k < 4; k++) begin
      run_window($sformatf("vec%0d", k), vecs[k].smp, 100, -1);
      check_results($sformatf("vec%0d", k), vecs[k].e);
    end

    // Acknowledge: back to IDLE, results held.
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("ack.res_valid", 64'(bus.res_valid), 64'd0);
    check("ack.busy", 64'(bus.busy), 64'd0);
    check_results("ack.hold", vecs[3].e);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < W; i++) w[i] = rand_sample();
      e = model(w);
      run_window($sformatf("rnd%0d", r), w, int'($urandom_range(30, 90)), 5);
      check_results($sformatf("rnd%0d", r), e);
    end

    // aclr in the middle of a window, after a result with nonzero outputs.
    run_window("pre_clr", vecs[0].smp, 100, -1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0100;
    repeat (7) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 aclr = 1'b1;
    #1;
    check("clr.busy", 64'(bus.busy), 64'd0);
    check("clr.in_ready", 64'(bus.in_ready), 64'd0);
    check("clr.res_valid", 64'(bus.res_valid), 64'd0);
    check_results("clr", '0);
    @(posedge clk); #1;
    aclr = 1'b0;
    @(negedge clk);
    check("clr.idle", 64'(bus.busy), 64'd0);
    run_window("post_clr", vecs[1].smp, 70, -1);
    check_results("post_clr", vecs[1].e);

    // start and res_ack together in DONE: start wins.
    bus.start = 1'b1;
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("both.busy", 64'(bus.busy), 64'd1);
    check("both.in_ready", 64'(bus.in_ready), 64'd1);
    check("both.res_valid", 64'(bus.res_valid), 64'd0);
    // Already in ACCUM, so the start pulse inside run_window is ignored.
    run_window("both", vecs[2].smp, 100, -1);
    check_results("both", vecs[2].e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
